// File: rtl/instr_queue_if.sv
// Fetch/decode side of the instruction queue: push, pop, flush and the
// show-ahead head entry.
interface instr_queue_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             enq;
  logic [WIDTH-1:0] ir_in;
  logic [WIDTH-1:0] pc_in;
  logic             full;
  logic             deq;
  logic             empty;
  logic [WIDTH-1:0] ir_out;
  logic [WIDTH-1:0] pc_out;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, enq, ir_in, pc_in, deq,
    input  full, empty, ir_out, pc_out, count
  );

  modport slave (
    input  flush, enq, ir_in, pc_in, deq,
    output full, empty, ir_out, pc_out, count
  );
endinterface

// File: rtl/instr_queue.sv
// Circular-buffer instruction queue between fetch and decode. Holds {pc, ir}
// pairs in program order and drops everything on a branch-redirect flush.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  instr_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] ir_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem [DEPTH];

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;

  logic is_full;
  logic is_empty;
  logic enq_ok;
  logic deq_ok;

  // Status comes only from the registered count, so enq/deq never reach full/empty.
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // A flush wins over any push or pop presented in the same cycle.
  assign enq_ok = q.enq && !is_full  && !q.flush;
  assign deq_ok = q.deq && !is_empty && !q.flush;

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (enq_ok) tail_ptr <= tail_ptr + PTR_W'(1);
      if (deq_ok) head_ptr <= head_ptr + PTR_W'(1);
      case ({enq_ok, deq_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately not reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && enq_ok) begin
      ir_mem[tail_ptr] <= q.ir_in;
      pc_mem[tail_ptr] <= q.pc_in;
    end
  end

  assign q.full   = is_full;
  assign q.empty  = is_empty;
  assign q.count  = count_q;
  assign q.ir_out = ir_mem[head_ptr];
  assign q.pc_out = pc_mem[head_ptr];
endmodule

// File: tb/tb_instr_queue.sv
// Directed testbench for instr_queue: reset, fill/drain, wrap, simultaneous
// push/pop, flush and underflow, all against hand-computed values.
module tb_instr_queue;
  logic clk;
  logic rst;
  int   errorCount;
  int   checkCount;

  instr_queue_if #(.DEPTH(8), .WIDTH(16)) q_if ();

  instr_queue #(.DEPTH(8), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then sample 1 time unit later.
  task automatic applyStimulus(input logic e, input logic d, input logic f,
                               input logic [15:0] ir, input logic [15:0] pc);
    q_if.enq   = e;
    q_if.deq   = d;
    q_if.flush = f;
    q_if.ir_in = ir;
    q_if.pc_in = pc;
    @(posedge clk);
    #1;
    q_if.enq   = 1'b0;
    q_if.deq   = 1'b0;
    q_if.flush = 1'b0;
  endtask

  task automatic checkHead(input string tag, input logic [15:0] ir, input logic [15:0] pc);
    checkOutput({tag, "_empty"}, 32'(q_if.empty), 32'd0);
    checkOutput({tag, "_ir"}, 32'(q_if.ir_out), 32'(ir));
    checkOutput({tag, "_pc"}, 32'(q_if.pc_out), 32'(pc));
  endtask

  task automatic checkCountFlags(input string tag, input int cnt);
    checkOutput({tag, "_count"}, 32'(q_if.count), 32'(cnt));
    checkOutput({tag, "_empty"}, 32'(q_if.empty), 32'(cnt == 0));
    checkOutput({tag, "_full"},  32'(q_if.full),  32'(cnt == 8));
  endtask

  initial begin
    logic [15:0] v;
    errorCount = 0;
    checkCount = 0;
    rst        = 1'b0;
    q_if.enq   = 1'b0;
    q_if.deq   = 1'b0;
    q_if.flush = 1'b0;
    q_if.ir_in = '0;
    q_if.pc_in = '0;
    #2;

    // Reset held two cycles with enq and deq both asserted.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hAAAA, 16'hBBBB);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hAAAA, 16'hBBBB);
    rst = 1'b0;
    checkCountFlags("reset", 0);

    // Fill with eight entries, drop a ninth, then drain in order.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i), 16'h3000 + 16'(2 * i));
      if (i == 0) checkHead("fill_first", 16'h1000, 16'h3000);
    end
    checkCountFlags("fill_full", 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hDEAD, 16'hDEAD);
    checkCountFlags("fill_drop", 8);
    for (int i = 0; i < 8; i++) begin
      checkHead("drain", 16'h1000 + 16'(i), 16'h3000 + 16'(2 * i));
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    end
    checkCountFlags("drain_end", 0);

    // Push 5, pop 5, then push 8 so both pointers wrap past the last slot.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h4000 + 16'(i), 16'h4100 + 16'(i));
    for (int i = 0; i < 5; i++) begin
      checkHead("wrap_pre", 16'h4000 + 16'(i), 16'h4100 + 16'(i));
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    end
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h5000 + 16'(i), 16'h6000 + 16'(i));
    checkCountFlags("wrap_full", 8);
    for (int i = 0; i < 8; i++) begin
      checkHead("wrap_pop", 16'h5000 + 16'(i), 16'h6000 + 16'(i));
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      checkOutput("wrap_count", 32'(q_if.count), 32'(7 - i));
    end
    checkCountFlags("wrap_end", 0);

    // Simultaneous push/pop at count 3 keeps count and order.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h7000 + 16'(i), 16'h7100 + 16'(i));
    for (int k = 0; k < 10; k++) begin
      checkHead("sim_head", 16'h7000 + 16'(k), 16'h7100 + 16'(k));
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h7003 + 16'(k), 16'h7103 + 16'(k));
      checkOutput("sim_count", 32'(q_if.count), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      checkHead("sim_tail", 16'h700A + 16'(i), 16'h710A + 16'(i));
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    end
    checkCountFlags("sim_end", 0);

    // Simultaneous push/pop while full: the pop happens, the push is dropped.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h8000 + 16'(i), 16'h8100 + 16'(i));
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hBAD0, 16'hBAD1);
    checkCountFlags("full_both", 7);
    for (int i = 1; i < 8; i++) begin
      checkHead("full_drain", 16'h8000 + 16'(i), 16'h8100 + 16'(i));
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    end
    checkCountFlags("full_drain_end", 0);

    // Flush at count 5 with a push in the same cycle.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h9000 + 16'(i), 16'h9100 + 16'(i));
    checkCountFlags("pre_flush", 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF);
    checkCountFlags("flush", 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h2222, 16'h3333);
    checkHead("post_flush", 16'h2222, 16'h3333);
    checkCountFlags("post_flush", 1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    checkCountFlags("post_flush_pop", 0);

    // Pops while empty change nothing; a following round-trip still works.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      checkCountFlags("underflow", 0);
    end
    v = 16'h5A5A;
    applyStimulus(1'b1, 1'b0, 1'b0, v, 16'h3456);
    checkHead("round_trip", 16'h5A5A, 16'h3456);
    checkCountFlags("round_trip", 1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    checkCountFlags("round_trip_end", 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
